// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, reset PC and the fetch FSM state encoding.
// The decoder imports the same width constants so jmp_addr and pc always agree.
package cpu_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] RESET_PC = 9'h000;

    typedef enum logic [2:0] {
        F0    = 3'd0,
        F1    = 3'd1,
        F2    = 3'd2,
        F3    = 3'd3,
        ISSUE = 3'd4,
        WAIT  = 3'd5,
        HALT  = 3'd6
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus: ROM read port, instruction hand-off to the decoder and fetch status.
// master = instr_fetch, slave = ROM/decoder side.
interface instr_fetch_if;
    import cpu_pkg::*;

    // ROM: rom_data returns the word at rom_addr one clock after it is presented.
    logic              rom_rd_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    // Handshake: cmd_start is a one-cycle pulse marking instr_byte/operand1/operand2/pc
    // valid; they stay stable until the decoder answers with a one-cycle instr_done
    // (sampled only while waiting), which also qualifies instr_size/jmp_en/jmp_addr/pc_hlt.
    logic [DATA_W-1:0] instr_byte;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic              cmd_start;
    logic              instr_done;
    logic [1:0]        instr_size;
    logic              jmp_en;
    logic [ADDR_W-1:0] jmp_addr;
    logic              pc_hlt;

    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              wdog_fault;
    fetch_state_e      dbg_state;

    modport master (
        output rom_rd_en, rom_addr, instr_byte, operand1, operand2, cmd_start,
               pc, halted, wdog_fault, dbg_state,
        input  rom_data, instr_done, instr_size, jmp_en, jmp_addr, pc_hlt
    );

    modport slave (
        input  rom_rd_en, rom_addr, instr_byte, operand1, operand2, cmd_start,
               pc, halted, wdog_fault, dbg_state,
        output rom_data, instr_done, instr_size, jmp_en, jmp_addr, pc_hlt
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads opcode + two operands from the ROM and hands
// them to the decoder. Optional WAIT watchdog enabled by defining FETCH_WDOG_EN.
module instr_fetch #(
    parameter logic [cpu_pkg::ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
`ifdef FETCH_WDOG_EN
    ,
    parameter int WDOG_CYC = 64
`endif
) (
    input  logic          clk,
    input  logic          sys_rst,
    instr_fetch_if.master bus
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    fetch_state_e      r_state, w_state;
    logic [ADDR_W-1:0] r_pc, w_pc;
    logic              r_rd_en, w_rd_en;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_instr, w_instr;
    logic [DATA_W-1:0] r_op1, w_op1;
    logic [DATA_W-1:0] r_op2, w_op2;
    logic              r_cmd, w_cmd;
    logic              r_halted, w_halted;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_target;

`ifdef FETCH_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYC + 1);
    logic [CNT_W-1:0] r_wcnt, w_wcnt;
    logic             r_wdog, w_wdog;
`endif

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= F0;
            r_pc     <= RESET_PC;
            r_rd_en  <= 1'b0;
            r_addr   <= RESET_PC;
            r_instr  <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_cmd    <= 1'b0;
            r_halted <= 1'b0;
`ifdef FETCH_WDOG_EN
            r_wcnt   <= '0;
            r_wdog   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_pc     <= w_pc;
            r_rd_en  <= w_rd_en;
            r_addr   <= w_addr;
            r_instr  <= w_instr;
            r_op1    <= w_op1;
            r_op2    <= w_op2;
            r_cmd    <= w_cmd;
            r_halted <= w_halted;
`ifdef FETCH_WDOG_EN
            r_wcnt   <= w_wcnt;
            r_wdog   <= w_wdog;
`endif
        end
    end

    // Outputs are registered on entry to a state, so each read address is already on
    // the bus during the state that issues it and the data is captured one state later.
    always_comb begin
        w_state  = r_state;
        w_pc     = r_pc;
        w_rd_en  = r_rd_en;
        w_addr   = r_addr;
        w_instr  = r_instr;
        w_op1    = r_op1;
        w_op2    = r_op2;
        w_cmd    = 1'b0;
        w_halted = r_halted;
        w_step   = (bus.instr_size == 2'd0) ? ONE : ADDR_W'(bus.instr_size);
        w_target = bus.jmp_en ? bus.jmp_addr : r_pc + w_step;
`ifdef FETCH_WDOG_EN
        w_wcnt   = r_wcnt;
        w_wdog   = r_wdog;
`endif
        case (r_state)
            F0: begin
                w_rd_en = 1'b1;
                w_addr  = r_pc + ONE;
                w_state = F1;
            end
            F1: begin
                w_instr = bus.rom_data;
                w_addr  = r_pc + TWO;
                w_state = F2;
            end
            F2: begin
                w_op1   = bus.rom_data;
                w_rd_en = 1'b0;
                w_state = F3;
            end
            F3: begin
                w_op2   = bus.rom_data;
                w_cmd   = 1'b1;
                w_state = ISSUE;
            end
            ISSUE: begin
`ifdef FETCH_WDOG_EN
                w_wcnt  = '0;
`endif
                w_state = WAIT;
            end
            WAIT: begin
`ifdef FETCH_WDOG_EN
                w_wcnt = r_wcnt + CNT_W'(1);
`endif
                if (bus.instr_done) begin
                    if (bus.pc_hlt) begin
                        w_halted = 1'b1;
                        w_state  = HALT;
                    end else begin
                        w_pc    = w_target;
                        w_addr  = w_target;
                        w_rd_en = 1'b1;
                        w_state = F0;
                    end
`ifdef FETCH_WDOG_EN
                end else if (r_wcnt == CNT_W'(WDOG_CYC - 1)) begin
                    w_wdog   = 1'b1;
                    w_halted = 1'b1;
                    w_state  = HALT;
`endif
                end
            end
            HALT: begin
                w_state = HALT;
            end
            default: begin
                w_state = F0;
            end
        endcase
    end

    assign bus.rom_rd_en  = r_rd_en;
    assign bus.rom_addr   = r_addr;
    assign bus.instr_byte = r_instr;
    assign bus.operand1   = r_op1;
    assign bus.operand2   = r_op2;
    assign bus.cmd_start  = r_cmd;
    assign bus.pc         = r_pc;
    assign bus.halted     = r_halted;
    assign bus.dbg_state  = r_state;
`ifdef FETCH_WDOG_EN
    assign bus.wdog_fault = r_wdog;
`else
    assign bus.wdog_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random ROM image and decoder responses, expected instruction
// bundles queued by a reference model and checked by a monitor on every cmd_start.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int W = ADDR_W + 3 * DATA_W;
  localparam int ROM_SZ = 1 << ADDR_W;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;

  instr_fetch_if bus();

  instr_fetch #(
    .RESET_PC(9'h000)
`ifdef FETCH_WDOG_EN
    , .WDOG_CYC(8)
`endif
  ) dut (
    .clk(clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  // ---------------- clock / reset / ROM ----------------
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:ROM_SZ-1];
  always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [ADDR_W-1:0] model_pc;
  logic prev_cmd = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: an instruction at p is the three ROM words at p, p+1, p+2 modulo ROM size.
  function automatic logic [W-1:0] exp_item(input logic [ADDR_W-1:0] p);
    int a0, a1, a2;
    a0 = int'(p);
    a1 = (a0 + 1) % ROM_SZ;
    a2 = (a0 + 2) % ROM_SZ;
    return {p, mem[a0], mem[a1], mem[a2]};
  endfunction

  function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] p, input int size);
    int step;
    step = (size == 0) ? 1 : size;
    return ADDR_W'((int'(p) + step) % ROM_SZ);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sys_rst) begin
      prev_cmd = 1'b0;
    end else begin
      if (bus.cmd_start) begin
        chk("cmd_start_single_cycle", 64'(prev_cmd), 64'(0));
        chk("cmd_start_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          chk("instr_bundle", 64'({bus.pc, bus.instr_byte, bus.operand1, bus.operand2}),
              64'(exp_q.pop_front()));
        end
      end
      prev_cmd = bus.cmd_start;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.instr_done = 1'b0;
    bus.instr_size = 2'($urandom_range(0, 3));
    bus.jmp_en     = 1'($urandom_range(0, 1));
    bus.jmp_addr   = ADDR_W'($urandom_range(0, ROM_SZ - 1));
    bus.pc_hlt     = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pc"},         64'(bus.pc),         64'(0));
    chk({tag, "_rom_rd_en"},  64'(bus.rom_rd_en),  64'(0));
    chk({tag, "_rom_addr"},   64'(bus.rom_addr),   64'(0));
    chk({tag, "_instr_byte"}, 64'(bus.instr_byte), 64'(0));
    chk({tag, "_operand1"},   64'(bus.operand1),   64'(0));
    chk({tag, "_operand2"},   64'(bus.operand2),   64'(0));
    chk({tag, "_cmd_start"},  64'(bus.cmd_start),  64'(0));
    chk({tag, "_halted"},     64'(bus.halted),     64'(0));
    chk({tag, "_wdog_fault"}, 64'(bus.wdog_fault), 64'(0));
    chk({tag, "_state"},      64'(bus.dbg_state),  64'(F0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    sys_rst = 1'b0;
    model_pc = 9'h000;
    exp_q.push_back(exp_item(model_pc));
  endtask

  task automatic wait_cmd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_start && n < 40);
    chk("cmd_start_arrived", 64'(bus.cmd_start), 64'(1));
  endtask

  // Called at the ISSUE negedge; answers from WAIT after a random delay.
  task automatic send_done(input int size, input bit jmp, input logic [ADDR_W-1:0] addr,
                           input bit hlt);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    bus.instr_done = 1'b1;
    bus.instr_size = 2'(size);
    bus.jmp_en     = jmp;
    bus.jmp_addr   = addr;
    bus.pc_hlt     = hlt;
    if (!hlt) begin
      model_pc = jmp ? addr : advance(model_pc, size);
      exp_q.push_back(exp_item(model_pc));
    end
    @(negedge clk);
    drive_idle();
    chk("pc_after_done", 64'(bus.pc), 64'(model_pc));
    if (!hlt) begin
      chk("rom_addr_after_done", 64'(bus.rom_addr), 64'(model_pc));
      chk("rom_rd_en_after_done", 64'(bus.rom_rd_en), 64'(1));
    end
    // A stray instr_done outside WAIT must be ignored.
    bus.instr_done = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.instr_done = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    logic [ADDR_W-1:0] hold_pc;

    for (int i = 0; i < ROM_SZ; i++) mem[i] = DATA_W'($urandom_range(0, 255));
    mem[0] = 8'h01;
    mem[1] = 8'hAA;
    mem[2] = 8'hBB;
    drive_idle();

    repeat (3) @(negedge clk);
    check_reset("reset");
    release_reset();
    wait_cmd(n);
    chk("first_latency", 64'(n), 64'(4));

    // Directed: advances, jumps, wrap at the top of the ROM and size 0.
    send_done(2, 1'b0, 9'h000, 1'b0); wait_cmd(n);
    send_done(3, 1'b0, 9'h000, 1'b0); wait_cmd(n);
    send_done(1, 1'b1, 9'h062, 1'b0); wait_cmd(n);
    send_done(2, 1'b1, 9'h1FE, 1'b0); wait_cmd(n);
    send_done(3, 1'b0, 9'h000, 1'b0); wait_cmd(n);
    send_done(1, 1'b1, 9'h1FF, 1'b0); wait_cmd(n);
    send_done(0, 1'b0, 9'h000, 1'b0); wait_cmd(n);

    // Random instruction stream.
    for (int i = 0; i < 25; i++) begin
      send_done($urandom_range(0, 3), ($urandom_range(0, 9) < 3),
                ADDR_W'($urandom_range(0, ROM_SZ - 1)), 1'b0);
      wait_cmd(n);
    end

    // Halt beats a simultaneous jump and is sticky.
    hold_pc = model_pc;
    send_done(2, 1'b1, 9'h0F0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.instr_done = 1'($urandom_range(0, 1));
      bus.pc_hlt     = 1'b0;
      bus.jmp_en     = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_halted", 64'(bus.halted), 64'(1));
      chk("halt_pc", 64'(bus.pc), 64'(hold_pc));
      chk("halt_rd_en", 64'(bus.rom_rd_en), 64'(0));
      chk("halt_cmd", 64'(bus.cmd_start), 64'(0));
    end
    drive_idle();

    // Reset out of HALT.
    sys_rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_reset("reset_from_halt");

    // Reset in the middle of F2 aborts without a pulse.
    release_reset();
    @(posedge clk);
    @(posedge clk);
    #2 sys_rst = 1'b1;
    exp_q.delete();
    #1 check_reset("reset_mid_f2");
    repeat (3) @(negedge clk);
    release_reset();
    wait_cmd(n);
    chk("latency_after_abort", 64'(n), 64'(4));
    for (int i = 0; i < 3; i++) begin
      send_done($urandom_range(1, 3), 1'b0, 9'h000, 1'b0);
      wait_cmd(n);
    end

`ifdef FETCH_WDOG_EN
    // instr_done on the 8th WAIT cycle wins over the watchdog.
    repeat (8) @(negedge clk);
    bus.instr_done = 1'b1;
    bus.instr_size = 2'd1;
    bus.jmp_en     = 1'b0;
    bus.pc_hlt     = 1'b0;
    model_pc = advance(model_pc, 1);
    exp_q.push_back(exp_item(model_pc));
    @(negedge clk);
    drive_idle();
    chk("wdog_late_done_fault", 64'(bus.wdog_fault), 64'(0));
    chk("wdog_late_done_halted", 64'(bus.halted), 64'(0));
    chk("wdog_late_done_pc", 64'(bus.pc), 64'(model_pc));
    wait_cmd(n);

    // No answer: fault after 8 WAIT cycles.
    repeat (8) @(negedge clk);
    chk("wdog_before_trip", 64'(bus.wdog_fault), 64'(0));
    @(negedge clk);
    chk("wdog_tripped", 64'(bus.wdog_fault), 64'(1));
    chk("wdog_halted", 64'(bus.halted), 64'(1));
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
